// File: rtl/lift_din_pingpong.sv
// rtl/lift_din_pingpong.sv - ping-pong row buffer streaming lane-major words out of the full half.
// Optional macro LIFT_BUFF_OVF_CHK_EN enables the sticky ovf_err protocol checker.
module lift_din_pingpong #(
   parameter int WORD_W   = 30,
   parameter int LANES    = 8,
   parameter int DEPTH    = 8,
   parameter int READ_LEN = 7,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [AW-1:0]           wt_addr,
   input  logic [LANES*WORD_W-1:0] din,
   input  logic                    we,
   input  logic                    write_done,
   output logic                    wr_ready,
   input  logic                    rd_en,
   output logic                    rd_avail,
   output logic [WORD_W-1:0]       dout,
   output logic                    dout_valid,
   output logic                    last_read_of_buffer,
   output logic [1:0]              buf_count,
   output logic                    ovf_err
);

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   logic              wsel_q, wsel_d;
   logic              rsel_q, rsel_d;
   logic [1:0]        full_q, full_d;
   logic [AW-1:0]     row_cnt_q, row_cnt_d;
   logic [LW-1:0]     lane_cnt_q, lane_cnt_d;
   logic [1:0]        buf_count_q, buf_count_d;

   logic [WORD_W-1:0] mem_q [LANES][2*DEPTH];
   logic [WORD_W-1:0] row_q [LANES];
   logic              v1_q, last1_q;
   logic [LW-1:0]     lane1_q;
   logic [WORD_W-1:0] dout_q;
   logic              dout_valid_q, last_q;

   logic wr_ok, accept, row_end, lane_end, half_end;

   assign wr_ok    = ~full_q[wsel_q];
   assign accept   = rd_en & full_q[rsel_q];
   assign row_end  = (row_cnt_q == AW'(READ_LEN - 1));
   assign lane_end = (lane_cnt_q == LW'(LANES - 1));
   assign half_end = accept & row_end & lane_end;

   // Read and write halves never collide: a half is written only while empty, read only while full.
   always_comb begin
      wsel_d     = wsel_q;
      rsel_d     = rsel_q;
      full_d     = full_q;
      row_cnt_d  = row_cnt_q;
      lane_cnt_d = lane_cnt_q;
      if (accept) begin
         if (row_end) begin
            row_cnt_d  = '0;
            lane_cnt_d = lane_end ? '0 : lane_cnt_q + 1'b1;
         end else begin
            row_cnt_d = row_cnt_q + 1'b1;
         end
      end
      if (half_end) begin
         full_d[rsel_q] = 1'b0;
         rsel_d         = ~rsel_q;
      end
      if (write_done && wr_ok) begin
         full_d[wsel_q] = 1'b1;
         wsel_d         = ~wsel_q;
      end
      buf_count_d = {1'b0, full_d[0]} + {1'b0, full_d[1]};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wsel_q      <= 1'b0;
         rsel_q      <= 1'b0;
         full_q      <= 2'b00;
         row_cnt_q   <= '0;
         lane_cnt_q  <= '0;
         buf_count_q <= 2'd0;
      end else begin
         wsel_q      <= wsel_d;
         rsel_q      <= rsel_d;
         full_q      <= full_d;
         row_cnt_q   <= row_cnt_d;
         lane_cnt_q  <= lane_cnt_d;
         buf_count_q <= buf_count_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (we && wr_ok)
            mem_q[k][{wsel_q, wt_addr}] <= din[k*WORD_W +: WORD_W];
         row_q[k] <= mem_q[k][{rsel_q, row_cnt_q}];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v1_q         <= 1'b0;
         last1_q      <= 1'b0;
         lane1_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         v1_q         <= accept;
         last1_q      <= half_end;
         lane1_q      <= lane_cnt_q;
         dout_valid_q <= v1_q;
         last_q       <= v1_q & last1_q;
         if (v1_q)
            dout_q <= row_q[lane1_q];
      end
   end

`ifdef LIFT_BUFF_OVF_CHK_EN
   logic ovf_q;
   always_ff @(posedge clk) begin
      if (!rst)
         ovf_q <= 1'b0;
      else if (((we | write_done) & ~wr_ok) | (rd_en & ~full_q[rsel_q]))
         ovf_q <= 1'b1;
   end
   assign ovf_err = ovf_q;
`else
   assign ovf_err = 1'b0;
`endif

   assign wr_ready            = wr_ok;
   assign rd_avail            = full_q[rsel_q];
   assign dout                = dout_q;
   assign dout_valid          = dout_valid_q;
   assign last_read_of_buffer = last_q;
   assign buf_count           = buf_count_q;

endmodule

// File: doc/lift_din_pingpong.md
Name: lift_din_pingpong

Overview:
- Parametrised ping-pong input buffer for the lift datapath.
- Accepts full-width rows of LANES words, one row per cycle, into the idle half.
- Streams words one per cycle out of the other half, lane-major, with a valid/ready style handshake.
- Generalises the fixed 8-lane, 30-bit, 7-read buffer: lane count, word width, depth and read length are parameters; full/empty status, back-pressure and a self-timed read sequencer are new.

Parameters:
- WORD_W, 30, bits per word.
- LANES, 8, words per written row (number of lane memories).
- DEPTH, 8, rows per half, power of two.
- READ_LEN, 7, rows read per lane per half; 1 <= READ_LEN <= DEPTH.
- AW, $clog2(DEPTH), row address width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- wt_addr  in  AW  row written in the current write half.
- din  in  LANES*WORD_W  row data; lane k occupies bits [k*WORD_W +: WORD_W].
- we  in  1  write strobe.
- write_done  in  1  1-cycle pulse closing the current write half.
- wr_ready  out  1  current write half is free.
- rd_en  in  1  consumer requests the next word.
- rd_avail  out  1  current read half is full.
- dout  out  WORD_W  read word.
- dout_valid  out  1  dout is valid this cycle.
- last_read_of_buffer  out  1  dout is the final word of a half.
- buf_count  out  2  number of full halves (0..2).
- ovf_err  out  1  sticky protocol error flag.

Behaviour:
- Storage: 2 halves x DEPTH rows x LANES lanes. Memory address is {half, row}.
- State:
  - wsel: current write half.
  - rsel: current read half.
  - full[1:0]: per-half full flag.
  - row_cnt: 0..READ_LEN-1.
  - lane_cnt: 0..LANES-1.
- Reset (rst==0 at a clk edge):
  - wsel=0, rsel=0, full=00, row_cnt=0, lane_cnt=0.
  - dout=0, dout_valid=0, last_read_of_buffer=0, ovf_err=0.
  - Memory contents are not cleared.
  - Reset mid-read discards in-flight words; no dout_valid after reset.
- Write path:
  - wr_ready = ~full[wsel].
  - we && wr_ready: lane k of din is written to row wt_addr of half wsel.
  - we && !wr_ready: the write is dropped.
  - write_done && wr_ready: full[wsel] is set and wsel toggles.
  - write_done with zero preceding writes still marks the half full; stale contents are read out.
  - write_done && !wr_ready: ignored.
- Read path:
  - rd_avail = full[rsel].
  - An accept is rd_en && rd_avail. rd_en while !rd_avail is ignored.
  - Each accept reads lane lane_cnt, row row_cnt of half rsel.
  - Order: row_cnt increments first. At row_cnt==READ_LEN-1, row_cnt returns to 0 and lane_cnt increments.
  - Rows READ_LEN..DEPTH-1 are never read.
  - On the accept with lane_cnt==LANES-1 and row_cnt==READ_LEN-1: full[rsel] clears, rsel toggles, both counters return to 0.
  - Back-to-back halves stream gap-free when the next half is already full.
- Latency:
  - Accept at edge T: registered memory output at T+1, registered lane mux at T+2.
  - dout_valid=1 and dout hold the word during cycle T+2; otherwise dout_valid=0 and dout holds its last value.
  - last_read_of_buffer is asserted with dout_valid for the final word of the half.
- Simultaneous events:
  - write_done on half A and read completion on half B in the same cycle both take effect; buf_count stays unchanged.
  - A half can never be written and read at once, because the full flags are mutually exclusive per half.
- buf_count = full[0] + full[1], registered with the flags.

Optional Feature:
- Macro LIFT_BUFF_OVF_CHK_EN.
- Defined: ovf_err is set when any of these occurs, and stays set until reset:
  - we && !wr_ready
  - write_done && !wr_ready
  - rd_en && !rd_avail
- Not defined: the checker logic is absent, ovf_err is tied to 0, and data-path behaviour is identical.

Test Plan:
- Default parameters: write rows 0..7 of half 0 with lane k = 100*k+row, then pulse write_done -> buf_count=1, rd_avail=1. Hold rd_en for 56 cycles -> dout sequence 0,1,..,6,100,..,106,..,706, starting 2 cycles after the first accept. last_read_of_buffer is asserted only with 706. Afterwards buf_count=0.
- Fill both halves (two write_done pulses) -> wr_ready=0, buf_count=2. A further we to row 3 with new data is dropped; reading half 0 then half 1 back-to-back gives 112 consecutive dout_valid cycles with original data.
- Toggle rd_en 1,0,1,0 -> dout_valid follows with 2-cycle lag, no skipped or duplicated words.
- Final read accept of half 0 in the same cycle as write_done for half 1 -> buf_count stays 1, rd_avail stays 1, rsel=1.
- Pulse rst=0 after 20 accepts -> next cycle dout_valid=0, buf_count=0, wr_ready=1. A new fill and read starts at lane 0 row 0.
- With LIFT_BUFF_OVF_CHK_EN, LANES=4, WORD_W=16, DEPTH=4, READ_LEN=4: rd_en with buf_count=0 sets ovf_err=1, which persists until rst=0. Without the macro, the same stimulus leaves ovf_err=0.
